// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: latches packed hex nibbles,
// scans digits round-robin with a blank guard cycle, leading-zero blanking and blink.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_ph_q, blink_ph_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] slot_val_q, slot_val_d;
  logic [NUM_DIGITS-1:0]   slot_dp_q, slot_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   lz_vec;
  logic                    upper_zero;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;
      4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;
      4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;
      4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;
      4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;
      4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;
      4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;
      4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

  assign tick = en && (presc_q == PW'(REFRESH_DIV - 1));

  // Digit k blanks only when it and every digit above it are zero.
  always_comb begin
    lz_vec     = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (slot_val_q[4*k +: 4] == 4'h0);
      lz_vec[k]  = upper_zero;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = slot_val_q[4*k +: 4];
        cur_dp    = slot_dp_q[k];
        cur_blank = (blank_lz && lz_vec[k]) || (blink_ph_q && blink_mask[k]);
      end
    end
  end

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    blink_ph_d   = blink_ph_q;
    shadow_val_d = load ? value : shadow_val_q;
    shadow_dp_d  = load ? dp_in : shadow_dp_q;
    slot_val_d   = slot_val_q;
    slot_dp_d    = slot_dp_q;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    an_d         = '1;
    frame_done_d = 1'b0;
    if (tick) begin
      // Guard cycle: pins stay dark while the new slot's data is latched.
      presc_d      = '0;
      idx_d        = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      frame_done_d = (idx_q == IW'(NUM_DIGITS - 1));
      slot_val_d   = shadow_val_d;
      slot_dp_d    = shadow_dp_d;
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else if (en) begin
      presc_d = presc_q + PW'(1);
      an_d    = ~(NUM_DIGITS'(1) << idx_q);
      seg_d   = cur_blank ? 7'h7F : hex2seg(cur_nib);
      dp_d    = cur_blank ? 1'b1 : ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      slot_val_q   <= '0;
      slot_dp_q    <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      slot_val_q   <= slot_val_d;
      slot_dp_q    <= slot_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with 4 digits, 4-cycle slots and 8-slot blink half-period.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BT = 8;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [3:0]    blink_mask;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  int            n_checks;
  int            n_fail;
  logic [7:0]    exp_q[$];

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz;
    int          digit;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  vec_t vecs[20];

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLINK_TICKS(BT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .blink_mask(blink_mask),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, ".seg"}, 32'(seg), 32'h7F);
    check({name, ".dp"}, 32'(dp), 32'h1);
    check({name, ".an"}, 32'(an), 32'hF);
    check({name, ".fd"}, 32'(frame_done), 32'h0);
  endtask

  // Step negedges until digit d is lit; a timeout is counted as a failure.
  task automatic wait_slot(input int d, output bit found);
    logic [3:0] target;
    target = ~(4'b0001 << d);
    found  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an === target) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_slot: digit %0d never lit, an=%b", d, an);
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    logic [6:0] code_12af[4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [7:0] exp_v;
    bit         ok;
    int         slot;
    int         ph;

    vecs[0]  = '{16'h0005, 4'b0000, 1'b1, 3, 7'h7F, 1'b1};
    vecs[1]  = '{16'h0005, 4'b0000, 1'b1, 2, 7'h7F, 1'b1};
    vecs[2]  = '{16'h0005, 4'b0000, 1'b1, 1, 7'h7F, 1'b1};
    vecs[3]  = '{16'h0005, 4'b0000, 1'b1, 0, 7'h12, 1'b1};
    vecs[4]  = '{16'h0005, 4'b0000, 1'b0, 3, 7'h40, 1'b1};
    vecs[5]  = '{16'h0005, 4'b0000, 1'b0, 1, 7'h40, 1'b1};
    vecs[6]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'h40, 1'b1};
    vecs[7]  = '{16'h0000, 4'b0000, 1'b1, 1, 7'h7F, 1'b1};
    vecs[8]  = '{16'h0F00, 4'b0000, 1'b1, 3, 7'h7F, 1'b1};
    vecs[9]  = '{16'h0F00, 4'b0000, 1'b1, 1, 7'h40, 1'b1};
    vecs[10] = '{16'h0F00, 4'b0000, 1'b1, 2, 7'h0E, 1'b1};
    vecs[11] = '{16'h3456, 4'b0100, 1'b0, 2, 7'h19, 1'b0};
    vecs[12] = '{16'h3456, 4'b0100, 1'b0, 1, 7'h12, 1'b1};
    vecs[13] = '{16'h789B, 4'b0000, 1'b0, 0, 7'h03, 1'b1};
    vecs[14] = '{16'h789B, 4'b0000, 1'b0, 3, 7'h78, 1'b1};
    vecs[15] = '{16'hCDE0, 4'b0000, 1'b0, 3, 7'h46, 1'b1};
    vecs[16] = '{16'hCDE0, 4'b0000, 1'b0, 2, 7'h21, 1'b1};
    vecs[17] = '{16'hCDE0, 4'b0000, 1'b0, 1, 7'h06, 1'b1};
    vecs[18] = '{16'h0005, 4'b1000, 1'b1, 3, 7'h7F, 1'b1};
    vecs[19] = '{16'h0090, 4'b0001, 1'b1, 1, 7'h10, 1'b1};

    code_12af[0] = 7'h0E;
    code_12af[1] = 7'h08;
    code_12af[2] = 7'h24;
    code_12af[3] = 7'h79;

    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    en         = 1'b1;
    load       = 1'b0;
    value      = '0;
    dp_in      = '0;
    blank_lz   = 1'b0;
    blink_mask = '0;
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    repeat (2) @(negedge clk);
    check_reset("reset_held");

    // Scan of 12AF: guard + 3 lit cycles per slot, frame_done every 16 cycles
    value = 16'h12AF;
    load  = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) load = 1'b0;
      slot    = k / RD;
      ph      = k % RD;
      exp_an  = (ph == 0) ? 4'hF : ~(4'b0001 << (slot % ND));
      exp_seg = (ph == 0) ? 7'h7F : (slot == 0) ? 7'h40 : code_12af[slot % ND];
      check("scan.an", 32'(an), 32'(exp_an));
      check("scan.seg", 32'(seg), 32'(exp_seg));
      check("scan.fd", 32'(frame_done), 32'((k > 0) && (k % 16 == 0)));
    end

    // Reset pulse mid-slot acts without a clock edge
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_midslot");
    @(negedge clk);

    // Blink of digit 0 on 8888: phase flips every 8 slots
    value      = 16'h8888;
    blink_mask = 4'b0001;
    load       = 1'b1;
    rst_n      = 1'b1;
    for (int k = 0; k < 40 * RD; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) load = 1'b0;
      slot = k / RD;
      ph   = k % RD;
      if (slot >= 1 && ph != 0) begin
        exp_seg = ((slot % ND == 0) && ((slot / BT) % 2 == 1)) ? 7'h7F : 7'h00;
        check("blink.seg", 32'(seg), 32'(exp_seg));
      end
    end
    blink_mask = '0;

    // Table vectors through the scoreboard queue
    foreach (vecs[i]) begin
      blank_lz = vecs[i].lz;
      drive_load(vecs[i].value, vecs[i].dp_in);
      repeat (8) @(negedge clk);
      exp_q.push_back({vecs[i].dpo, vecs[i].seg});
      wait_slot(vecs[i].digit, ok);
      exp_v = exp_q.pop_front();
      if (ok) check($sformatf("vec%0d", i), 32'({dp, seg}), 32'(exp_v));
    end

    // Mid-slot load: digit 2 keeps its old code until its next slot
    blank_lz = 1'b0;
    drive_load(16'h3333, 4'b0000);
    repeat (8) @(negedge clk);
    wait_slot(1, ok);
    wait_slot(2, ok);
    value = 16'hFFFF;
    dp_in = 4'b0100;
    load  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      load = 1'b0;
      check("midload.old_seg", 32'(seg), 32'h30);
      check("midload.old_dp", 32'(dp), 32'h1);
    end
    wait_slot(3, ok);
    if (ok) check("midload.d3", 32'({dp, seg}), 32'({1'b1, 7'h0E}));
    wait_slot(2, ok);
    if (ok) check("midload.d2", 32'({dp, seg}), 32'({1'b0, 7'h0E}));
    wait_slot(1, ok);
    if (ok) check("midload.d1", 32'({dp, seg}), 32'({1'b1, 7'h0E}));

    // en low holds the scan in place and keeps pins dark
    wait_slot(2, ok);
    wait_slot(1, ok);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("en0.an", 32'(an), 32'hF);
      check("en0.seg", 32'(seg), 32'h7F);
      check("en0.dp", 32'(dp), 32'h1);
      check("en0.fd", 32'(frame_done), 32'h0);
    end
    en = 1'b1;
    @(negedge clk);
    check("resume.an0", 32'(an), 32'hD);
    @(negedge clk);
    check("resume.an1", 32'(an), 32'hD);
    @(negedge clk);
    check("resume.guard", 32'(an), 32'hF);
    @(negedge clk);
    check("resume.next", 32'(an), 32'hB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit common-anode 7-segment display, generalising the team's single-digit hex decoder.
- Latches a packed hex value, scans digits round-robin with a programmable refresh prescaler and adds per-digit decimal points, leading-zero blanking, per-digit blink and an anti-ghosting blank cycle.
- Sits between datapath debug registers (PC, ALU result) and board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 50000, clk cycles per digit slot (>=2).
- BLINK_TICKS, 128, digit slots per blink half-period (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  1 = scan active; 0 = display dark, counters held.
- load  input  1  capture value/dp_in into shadow registers this edge.
- value  input  4*NUM_DIGITS  packed hex nibbles, digit 0 = bits [3:0] (least significant).
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  input  1  1 = blank leading zero digits.
- blink_mask  input  NUM_DIGITS  1 = digit blinks.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  NUM_DIGITS  digit enables, active-low, one-hot-low or all-ones.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (async, rst_n=0): seg=7'h7F, dp=1, an=all ones, frame_done=0; prescaler=0, digit index=0, blink phase=0, blink counter=0, shadow value=0, shadow dp=0.
- All outputs are registered; no combinational path from inputs to pins.
- Shadow load: load=1 captures value/dp_in on that edge. Pins reflect new data from the next slot of each digit, never mid-slot. blank_lz and blink_mask are used live.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. "tick" = terminal count.
- On tick:
  - digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - frame_done=1 for that cycle if the index was NUM_DIGITS-1.
  - Blink counter increments; at BLINK_TICKS-1 it wraps and blink phase toggles.
- Ghost guard: in the cycle after a tick, an=all ones and seg=7'h7F. From the following cycle until the next tick, an has bit[index]=0.
- Segment encoding:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, active-low).
  - dp = ~shadow_dp[index].
- Leading-zero blank: with blank_lz=1, digit k>0 is blanked if it and every digit above it are 0. Digit 0 is never blanked by this rule.
- Blink: blink phase=1 and blink_mask[index]=1 blanks the digit.
- A blanked digit keeps its an low but drives seg=7'h7F and dp=1.
- en=0: next edge an=all ones, seg=7'h7F, dp=1, frame_done=0. Prescaler, index and blink state hold. On en=1 the scan resumes from the held state.
- Simultaneous load and tick: the new shadow data is used for the slot that starts at that tick.
- Reset mid-scan returns immediately to reset values. First tick after release comes REFRESH_DIV cycles later.

Test Plan:
- Reset and scan (NUM_DIGITS=4, REFRESH_DIV=4), load value=16'h12AF:
  - an sequence is 1111 (guard), 1110 for 3 cycles, 1111, 1101, ...
  - seg for digit 0..3 = 0E, 08, 24, 79.
  - frame_done pulses once every 16 cycles.
- Leading zero, value=16'h0005, blank_lz=1:
  - digits 3..1 give seg=7F with an low.
  - digit 0 gives seg=12.
  - With blank_lz=0, digits 3..1 give seg=40.
- value=16'h0000, blank_lz=1: only digit 0 lit, seg=40.
- Blink, BLINK_TICKS=8, blink_mask=4'b0001, value=16'h8888:
  - digit 0 is seg=00 for 8 slots, then 7F for 8 slots.
  - Other digits stay 00.
- Mid-slot load: load 16'hFFFF during digit 2's slot. seg holds the old digit 2 code until its next slot. dp_in=4'b0100 then gives dp=0 only on digit 2.
- Control edges:
  - en=0 for 10 cycles: an=1111, no frame_done. Index resumes unchanged.
  - rst_n pulse mid-slot: outputs return to reset values asynchronously.
